wave_sel_stepper: RTL and testbench

- Parametrised up/down selection counter for the DDS wave-control path.
- Converts debounced key pulses into a bounded selection index.
- Adds over a plain modulo pulse counter:
  - programmable modulus;
  - wrap or saturate at the ends;
  - direct load;
  - hold-to-auto-repeat;
  - a one-hot decode and a change strobe for the wave-select mux and display logic.

---
 rtl/wave_ctrl_pkg.sv | 25 ++
 rtl/key_repeat_gen.sv | 87 ++++++++
 rtl/wave_sel_stepper.sv | 99 +++++++++
 tb/tb_wave_sel_stepper.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_ctrl_pkg.sv
// Shared definitions for the DDS wave-control path: auto-repeat FSM
// encoding, key direction, and the default repeat timing for a 50 MHz
// sys_clk (also used by the key debounce block).
package wave_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } rpt_dir_e;

  // 0.5 s initial hold, then one step every 0.1 s at 50 MHz
  localparam int unsigned HOLD_CYC_DEF = 25_000_000;
  localparam int unsigned RPT_CYC_DEF  = 5_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_repeat_gen.sv
// Hold-to-auto-repeat generator: after a key pulse, keeps watching the
// key level and emits single-cycle repeat ticks, first after HOLD_CYC
// cycles and then every RPT_CYC cycles. HOLD_CYC = 0 disables it.
module key_repeat_gen
  import wave_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
  parameter int unsigned RPT_CYC  = RPT_CYC_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic inc_pulse,
  input  logic dec_pulse,
  input  logic inc_level,
  input  logic dec_level,
  output logic rpt_inc,
  output logic rpt_dec
);

  localparam int unsigned TMR_W = $clog2(max_u(HOLD_CYC, RPT_CYC) + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(RPT_CYC - 1);

  rpt_state_e       state_q;
  rpt_dir_e         dir_q;
  logic [TMR_W-1:0] timer_q;

  logic single_pulse;
  logic opp_pulse;
  logic dir_level;
  logic at_last;
  logic tick;

  // Decode tick from registered state so the step lands exactly
  // HOLD_CYC / RPT_CYC cycles after the anchor pulse.
  always_comb begin
    single_pulse = inc_pulse ^ dec_pulse;
    dir_level    = (dir_q == DIR_INC) ? inc_level : dec_level;
    opp_pulse    = single_pulse && ((dir_q == DIR_INC) ? dec_pulse : inc_pulse);
    at_last      = (state_q == ST_HOLD) ? (timer_q == HOLD_LAST) : (timer_q == RPT_LAST);
    tick         = (state_q != ST_IDLE) && !opp_pulse && dir_level && at_last;
    rpt_inc      = tick && (dir_q == DIR_INC);
    rpt_dec      = tick && (dir_q == DIR_DEC);
  end

  // Repeat FSM and hold/repeat timer
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_INC;
      timer_q <= '0;
    end else if (HOLD_CYC == 0) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (single_pulse) begin
            dir_q   <= inc_pulse ? DIR_INC : DIR_DEC;
            timer_q <= '0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD, ST_RPT: begin
          if (opp_pulse) begin
            dir_q   <= (dir_q == DIR_INC) ? DIR_DEC : DIR_INC;
            timer_q <= '0;
            state_q <= ST_HOLD;
          end else if (!dir_level) begin
            timer_q <= '0;
            state_q <= ST_IDLE;
          end else if (at_last) begin
            timer_q <= '0;
            state_q <= ST_RPT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          timer_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/wave_sel_stepper.sv
// Bounded up/down selection index for the wave-select mux: key pulses and
// auto-repeat ticks step the index, with wrap or saturate at the ends,
// clamped direct load, one-hot decode and a change strobe.
module wave_sel_stepper
  import wave_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned CNT_MAX  = 3,
  parameter int unsigned WRAP     = 1,
  parameter int unsigned RST_VAL  = 0,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
  parameter int unsigned RPT_CYC  = RPT_CYC_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             inc_pulse,
  input  logic             dec_pulse,
  input  logic             inc_level,
  input  logic             dec_level,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt_out,
  output logic [CNT_MAX:0] cnt_onehot,
  output logic             cnt_chg,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] RST_V = CNT_W'(RST_VAL);

  logic             rpt_inc;
  logic             rpt_dec;
  logic             inc_step;
  logic             dec_step;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_MAX:0] onehot_nxt;

  key_repeat_gen #(
    .HOLD_CYC (HOLD_CYC),
    .RPT_CYC  (RPT_CYC)
  ) u_key_repeat_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .inc_level (inc_level),
    .dec_level (dec_level),
    .rpt_inc   (rpt_inc),
    .rpt_dec   (rpt_dec)
  );

  // Next index: load beats steps; opposing steps cancel; ends are found
  // by comparing against CNT_MAX so non-power-of-2 moduli work.
  always_comb begin
    inc_step = inc_pulse | rpt_inc;
    dec_step = dec_pulse | rpt_dec;
    cnt_nxt  = cnt_out;
    if (load_en) begin
      cnt_nxt = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (inc_step && dec_step) begin
      cnt_nxt = cnt_out;
    end else if (inc_step) begin
      if (cnt_out >= MAX_V) cnt_nxt = (WRAP != 0) ? '0 : MAX_V;
      else                  cnt_nxt = cnt_out + CNT_W'(1);
    end else if (dec_step) begin
      if (cnt_out == '0) cnt_nxt = (WRAP != 0) ? MAX_V : '0;
      else               cnt_nxt = cnt_out - CNT_W'(1);
    end
  end

  // One-hot decode of the next index
  always_comb begin
    onehot_nxt = '0;
    for (int unsigned i = 0; i <= CNT_MAX; i++) begin
      onehot_nxt[i] = (cnt_nxt == CNT_W'(i));
    end
  end

  // Registered index, decode, end flags and change strobe
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_out <= RST_V;
      for (int unsigned i = 0; i <= CNT_MAX; i++) begin
        cnt_onehot[i] <= (i == RST_VAL);
      end
      cnt_chg <= 1'b0;
      at_min  <= (RST_V == '0);
      at_max  <= (RST_V == MAX_V);
    end else begin
      cnt_out    <= cnt_nxt;
      cnt_onehot <= onehot_nxt;
      cnt_chg    <= (cnt_nxt != cnt_out);
      at_min     <= (cnt_nxt == '0);
      at_max     <= (cnt_nxt == MAX_V);
    end
  end

endmodule

// File: tb/tb_wave_sel_stepper.sv
// Self-checking bench for wave_sel_stepper: a wrapping and a saturating
// instance share stimulus; a cycle-level reference model built from
// elapsed-time arithmetic predicts both every cycle.
module tb_wave_sel_stepper;

  localparam int CW   = 3;
  localparam int CMAX = 4;
  localparam int HOLD = 8;
  localparam int RPT  = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          inc_pulse, dec_pulse, inc_level, dec_level, load_en;
  logic [CW-1:0] load_val;

  logic [CW-1:0] w_cnt, s_cnt;
  logic [CMAX:0] w_oh, s_oh;
  logic          w_chg, s_chg, w_min, s_min, w_max, s_max;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int m_act, m_dir, m_anchor, cyc;
  int mw_cnt, ms_cnt, mw_chg, ms_chg;

  int seq_idx;
  int chg_log[$];

  wave_sel_stepper #(
    .CNT_W(CW), .CNT_MAX(CMAX), .WRAP(1), .RST_VAL(0), .HOLD_CYC(HOLD), .RPT_CYC(RPT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .inc_level(inc_level), .dec_level(dec_level),
    .load_en(load_en), .load_val(load_val),
    .cnt_out(w_cnt), .cnt_onehot(w_oh), .cnt_chg(w_chg),
    .at_min(w_min), .at_max(w_max)
  );

  wave_sel_stepper #(
    .CNT_W(CW), .CNT_MAX(CMAX), .WRAP(0), .RST_VAL(0), .HOLD_CYC(HOLD), .RPT_CYC(RPT)
  ) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .inc_level(inc_level), .dec_level(dec_level),
    .load_en(load_en), .load_val(load_val),
    .cnt_out(s_cnt), .cnt_onehot(s_oh), .cnt_chg(s_chg),
    .at_min(s_min), .at_max(s_max)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int apply(input int cnt, input int wrap, input int is, input int ds,
                               input int ld, input int lv);
    if (ld != 0) return (lv > CMAX) ? CMAX : lv;
    if (is != 0 && ds != 0) return cnt;
    if (is != 0) return (cnt == CMAX) ? (wrap != 0 ? 0 : CMAX) : cnt + 1;
    if (ds != 0) return (cnt == 0) ? (wrap != 0 ? CMAX : 0) : cnt - 1;
    return cnt;
  endfunction

  task automatic model_reset();
    m_act = 0; m_dir = 0; m_anchor = 0;
    mw_cnt = 0; ms_cnt = 0; mw_chg = 0; ms_chg = 0;
  endtask

  // Repeat ticks come from time elapsed since the anchoring press:
  // first at HOLD cycles, then every RPT cycles, while the key stays held.
  task automatic model_step();
    int ti, td, single, opp, lvl, el, nw, ns;
    ti = 0; td = 0;
    single = int'(inc_pulse ^ dec_pulse);
    if (m_act != 0) begin
      lvl = (m_dir != 0) ? int'(dec_level) : int'(inc_level);
      opp = single != 0 && ((m_dir != 0) ? inc_pulse : dec_pulse);
      el  = cyc - m_anchor;
      if (opp != 0) begin
        m_dir = int'(dec_pulse); m_anchor = cyc;
      end else if (lvl == 0) begin
        m_act = 0;
      end else if (el >= HOLD && ((el - HOLD) % RPT) == 0) begin
        if (m_dir != 0) td = 1; else ti = 1;
      end
    end else if (single != 0) begin
      m_act = 1; m_dir = int'(dec_pulse); m_anchor = cyc;
    end
    nw = apply(mw_cnt, 1, int'(inc_pulse) | ti, int'(dec_pulse) | td, int'(load_en), int'(load_val));
    ns = apply(ms_cnt, 0, int'(inc_pulse) | ti, int'(dec_pulse) | td, int'(load_en), int'(load_val));
    mw_chg = int'(nw != mw_cnt); ms_chg = int'(ns != ms_cnt);
    mw_cnt = nw; ms_cnt = ns;
    cyc++;
  endtask

  task automatic check_model();
    chk("w_cnt", int'(w_cnt), mw_cnt);
    chk("w_onehot", int'(w_oh), 1 << mw_cnt);
    chk("w_chg", int'(w_chg), mw_chg);
    chk("w_at_min", int'(w_min), int'(mw_cnt == 0));
    chk("w_at_max", int'(w_max), int'(mw_cnt == CMAX));
    chk("s_cnt", int'(s_cnt), ms_cnt);
    chk("s_onehot", int'(s_oh), 1 << ms_cnt);
    chk("s_chg", int'(s_chg), ms_chg);
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later,
  // then single-cycle strobes are dropped.
  task automatic step_clk();
    @(posedge sys_clk);
    model_step();
    #1;
    check_model();
    if (w_chg) chg_log.push_back(seq_idx);
    seq_idx++;
    inc_pulse = 1'b0; dec_pulse = 1'b0; load_en = 1'b0;
  endtask

  task automatic drive(input logic i, input logic d, input logic l, input logic [CW-1:0] v);
    inc_pulse = i; dec_pulse = d; load_en = l; load_val = v;
    step_clk();
  endtask

  task automatic start_seq();
    seq_idx = 0;
    chg_log.delete();
  endtask

  typedef struct {
    int inc, dec, ld, lv;   // stimulus
    int wc, wg, sc, sg;     // wrap cnt/chg, saturate cnt/chg
  } vec_t;

  vec_t tbl[17];

  initial begin
    int exp_a[4];
    int exp_b[4];

    tbl = '{
      '{1,0,0,0, 1,1, 1,1},
      '{1,0,0,0, 2,1, 2,1},
      '{1,0,0,0, 3,1, 3,1},
      '{1,0,0,0, 4,1, 4,1},
      '{1,0,0,0, 0,1, 4,0},
      '{1,0,0,0, 1,1, 4,0},
      '{0,0,1,0, 0,1, 0,1},
      '{0,1,0,0, 4,1, 0,0},
      '{0,0,0,0, 4,0, 0,0},
      '{0,0,1,7, 4,0, 4,1},
      '{0,0,1,1, 1,1, 1,1},
      '{1,0,1,2, 2,1, 2,1},
      '{1,1,0,0, 2,0, 2,0},
      '{0,0,1,2, 2,0, 2,0},
      '{0,1,0,0, 1,1, 1,1},
      '{0,1,0,0, 0,1, 0,1},
      '{0,1,0,0, 4,1, 0,0}
    };
    exp_a = '{0, 8, 12, 16};
    exp_b = '{0, 6, 14, 18};

    sys_rst_n = 1'b0;
    inc_pulse = 1'b0; dec_pulse = 1'b0; inc_level = 1'b0; dec_level = 1'b0;
    load_en = 1'b0; load_val = '0;
    cyc = 0; seq_idx = 0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_cnt", int'(w_cnt), 0);
    chk("rst_onehot", int'(w_oh), 1);
    chk("rst_chg", int'(w_chg), 0);
    chk("rst_at_min", int'(w_min), 1);
    chk("rst_at_max", int'(w_max), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // directed vectors with levels low
    for (int i = 0; i < 17; i++) begin
      inc_pulse = tbl[i].inc[0];
      dec_pulse = tbl[i].dec[0];
      load_en   = tbl[i].ld[0];
      load_val  = CW'(tbl[i].lv);
      step_clk();
      chk($sformatf("tbl%0d_w_cnt", i), int'(w_cnt), tbl[i].wc);
      chk($sformatf("tbl%0d_w_chg", i), int'(w_chg), tbl[i].wg);
      chk($sformatf("tbl%0d_w_onehot", i), int'(w_oh), 1 << tbl[i].wc);
      chk($sformatf("tbl%0d_w_at_max", i), int'(w_max), int'(tbl[i].wc == CMAX));
      chk($sformatf("tbl%0d_s_cnt", i), int'(s_cnt), tbl[i].sc);
      chk($sformatf("tbl%0d_s_chg", i), int'(s_chg), tbl[i].sg);
    end

    // auto-repeat: press inc, hold 20 cycles, release
    drive(1'b0, 1'b0, 1'b1, 3'd0);
    start_seq();
    inc_level = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (19) step_clk();
    inc_level = 1'b0;
    repeat (10) step_clk();
    chk("rpt_steps", chg_log.size(), 4);
    for (int i = 0; i < 4 && i < chg_log.size(); i++)
      chk($sformatf("rpt_step%0d_at", i), chg_log[i], exp_a[i]);
    chk("rpt_final_cnt", int'(w_cnt), 4);

    // direction switch while holding inc
    drive(1'b0, 1'b0, 1'b1, 3'd2);
    start_seq();
    inc_level = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (5) step_clk();
    dec_level = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 3'd0);
    inc_level = 1'b0;
    repeat (13) step_clk();
    dec_level = 1'b0;
    repeat (5) step_clk();
    chk("sw_steps", chg_log.size(), 4);
    for (int i = 0; i < 4 && i < chg_log.size(); i++)
      chk($sformatf("sw_step%0d_at", i), chg_log[i], exp_b[i]);
    chk("sw_final_cnt", int'(w_cnt), 0);
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    chk("both_chg", int'(w_chg), 0);
    chk("both_cnt", int'(w_cnt), 0);

    // asynchronous reset while in repeat
    drive(1'b0, 1'b0, 1'b1, 3'd0);
    inc_level = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (14) step_clk();
    chk("pre_rst_cnt", int'(w_cnt), 3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_cnt", int'(w_cnt), 0);
    chk("arst_onehot", int'(w_oh), 1);
    chk("arst_chg", int'(w_chg), 0);
    chk("arst_at_min", int'(w_min), 1);
    chk("arst_at_max", int'(w_max), 0);
    chk("arst_s_cnt", int'(s_cnt), 0);
    model_reset();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    start_seq();
    repeat (20) step_clk();
    chk("post_rst_steps", chg_log.size(), 0);
    chk("post_rst_cnt", int'(w_cnt), 0);
    inc_level = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      inc_pulse = ($urandom_range(0, 9) == 0);
      dec_pulse = ($urandom_range(0, 9) == 0);
      if (inc_pulse && $urandom_range(0, 1) == 1) inc_level = 1'b1;
      if (dec_pulse && $urandom_range(0, 1) == 1) dec_level = 1'b1;
      if ($urandom_range(0, 11) == 0) inc_level = ~inc_level;
      if ($urandom_range(0, 11) == 0) dec_level = ~dec_level;
      load_en  = ($urandom_range(0, 24) == 0);
      load_val = CW'($urandom);
      step_clk();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
